board_arbiter: RTL and testbench
================================

# board_arbiter

Sequencer and arbiter for the single-port 10x20 playfield memory. It shares the board RAM between the game-logic engine (collision reads, lock writes) and the VGA renderer (pixel-cell reads), and it runs a full-board clear sweep on request. It sits between `gamelogic`/renderer and the synchronous-read board RAM, replacing their direct `board_*` connections.

## Interface
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- VID_MAX_WAIT, 4, consecutive denied cycles after which the renderer wins contention (1..15)

- CLOCK_50  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- clear_req  in  1  single-cycle pulse: start a full-board clear
- clear_busy  out  1  high while the clear sweep runs
- game_req  in  1  game access request, held until granted
- game_we  in  1  1 = write, 0 = read
- game_x / game_y  in  4 / 5  cell coordinate
- game_wdata  in  1  write data
- game_gnt  out  1  request accepted this cycle (combinational)
- game_rvalid / game_rdata  out  1 / 1  read return
- vid_req  in  1  renderer read request, held until granted
- vid_x / vid_y  in  4 / 5  cell coordinate
- vid_gnt  out  1  request accepted this cycle (combinational)
- vid_rvalid / vid_rdata  out  1 / 1  read return
- mem_re / mem_we  out  1 / 1  RAM read / write strobe (registered)
- mem_x / mem_y / mem_wdata  out  4 / 5 / 1  RAM address and data (registered)
- mem_rdata  in  1  RAM read data, valid 1 cycle after `mem_re`

## Operation
- States: ARB, CLEAR.
- In ARB, at most one grant per cycle.
  - Only one requester active: that requester is granted.
  - Both active: game wins, unless `vid_wait == VID_MAX_WAIT`, in which case vid wins.
- `vid_wait` (4 bits):
  - Increments on each cycle with `vid_req` high and `vid_gnt` low, saturating at VID_MAX_WAIT.
  - Clears on `vid_gnt` or when `vid_req` is low.
- Granted access: the selected coordinate, `we` and data are registered onto `mem_*`. `mem_re` = !we, `mem_we` = we.
- Out-of-range coordinate (x ≥ COLS or y ≥ ROWS):
  - The access is still granted.
  - `mem_re` and `mem_we` stay 0.
  - A read returns the constant 1 to game (wall semantics for collision) and 0 to vid.
- Read return:
  - Each read carries a 1-bit owner tag and an out-of-range flag through a 2-stage valid pipeline.
  - `<owner>_rvalid` pulses for one cycle.
  - `<owner>_rdata` = `mem_rdata` (or the out-of-range constant) while rvalid is high, 0 otherwise.
- `clear_req` seen in ARB:
  - Enter CLEAR on the next edge. No grant in the `clear_req` cycle, even if requests are pending.
- CLEAR sweep:
  - Writes 0 to every cell, row-major from (0,0) to (COLS-1, ROWS-1), one cell per cycle (COLS*ROWS = 200 writes).
  - No grants during CLEAR.
  - Returns to ARB after the final write is issued.
- `clear_req` during CLEAR is ignored.
- In-flight reads complete normally across the ARB→CLEAR transition.

## Timing
- Read latency, request to return:
  - Cycle N: `req` high and `gnt` high.
  - Cycle N+1: `mem_*` driven.
  - Cycle N+2: `rvalid` high.
- Throughput: one access per cycle. Back-to-back grants are allowed, and each returns in order.
- Writes complete at the RAM edge ending cycle N+1. No response signal for writes.
- A write followed by a read of the same cell in the next cycle returns the new value (RAM write-before-read is not required; accesses are serialised by one cycle).
- `clear_busy`:
  - Rises on the edge after `clear_req`.
  - Is high for exactly 200 cycles.
  - Falls on the edge after the last write.
  - First post-clear grant is possible in the cycle `clear_busy` is low.
- Reset (asynchronous, `resetn` = 0):
  - State = ARB, `vid_wait` = 0, pipeline cleared.
  - All outputs 0: `mem_re`, `mem_we`, `mem_x`, `mem_y`, `mem_wdata`, both `gnt`, both `rvalid`, both `rdata`, `clear_busy`.
- Reset mid-clear: the sweep aborts immediately and no further writes are issued. Reset mid-read: the pending rvalid is dropped.

## Test plan
- Game read alone: `game_req`=1, we=0, (3,5), RAM cell=1.
  - Required: `game_gnt` the same cycle; `mem_re`=1, `mem_x`=3, `mem_y`=5 the next cycle; `game_rvalid`=1 and `game_rdata`=1 two cycles after grant; `vid_rvalid` stays 0.
- Contention: `game_req` and `vid_req` held high continuously.
  - Required: game granted 4 cycles, then vid granted 1 cycle; the pattern repeats (VID_MAX_WAIT=4); returns are tagged to the correct owner.
- Out of range: game read (10,0) and vid read (0,20).
  - Required: both granted; `mem_re`=0; `game_rdata`=1 and `vid_rdata`=0 at their rvalid cycles.
- Clear: pulse `clear_req` while `game_req`=1.
  - Required: no `game_gnt` for 201 cycles; `clear_busy` high for exactly 200 cycles; 200 `mem_we` pulses with `mem_wdata`=0, first (0,0), last (9,19); game granted the cycle after `clear_busy` falls.
- Write then read: game write (4,7)=1, then a read of (4,7) in the next cycle.
  - Required: `mem_we` then `mem_re` on consecutive cycles; `game_rdata`=1.
- Reset at cycle 50 of a clear:
  - Required: `mem_we` drops asynchronously, `clear_busy`=0, state ARB; no writes after `resetn` rises.

Source files
------------

// File: rtl/board_arbiter.sv
// board_arbiter: shares the single-port board RAM between game logic and renderer,
// and sweeps the whole board to zero on request.
module board_arbiter #(
   parameter int COLS = 10,
   parameter int ROWS = 20,
   parameter int VID_MAX_WAIT = 4
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       clear_req,
   output logic       clear_busy,
   input  logic       game_req,
   input  logic       game_we,
   input  logic [3:0] game_x,
   input  logic [4:0] game_y,
   input  logic       game_wdata,
   output logic       game_gnt,
   output logic       game_rvalid,
   output logic       game_rdata,
   input  logic       vid_req,
   input  logic [3:0] vid_x,
   input  logic [4:0] vid_y,
   output logic       vid_gnt,
   output logic       vid_rvalid,
   output logic       vid_rdata,
   output logic       mem_re,
   output logic       mem_we,
   output logic [3:0] mem_x,
   output logic [4:0] mem_y,
   output logic       mem_wdata,
   input  logic       mem_rdata
);
   localparam logic [3:0] XMAX = 4'(COLS - 1);
   localparam logic [4:0] YMAX = 5'(ROWS - 1);
   localparam logic [3:0] VMAX = 4'(VID_MAX_WAIT);

   typedef enum logic {ARB, CLEAR} state_t;
   state_t state, state_nx;
   logic [3:0] vid_wait, clr_x, acc_x;
   logic [4:0] clr_y, acc_y;
   logic clr, acc, acc_we, acc_wd, in_range;
   logic p1_v, p1_own, p1_oor, p2_v, p2_own, p2_oor;

   // grants are gated by resetn so both stay low while reset is held
   always_comb begin
      state_nx = state;
      game_gnt = 1'b0;
      vid_gnt = 1'b0;
      if (state == CLEAR) begin
         if (clr_x == XMAX && clr_y == YMAX) state_nx = ARB;
      end else if (clear_req) begin
         state_nx = CLEAR;
      end else if (resetn) begin
         vid_gnt = vid_req && (!game_req || vid_wait == VMAX);
         game_gnt = game_req && !vid_gnt;
      end
   end

   assign clr = state == CLEAR;
   assign clear_busy = clr;
   assign acc = game_gnt || vid_gnt;
   assign acc_x = vid_gnt ? vid_x : game_x;
   assign acc_y = vid_gnt ? vid_y : game_y;
   assign acc_we = game_gnt && game_we;
   assign acc_wd = game_gnt && game_wdata;
   assign in_range = acc_x <= XMAX && acc_y <= YMAX;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state <= ARB;
         vid_wait <= '0;
         clr_x <= '0;
         clr_y <= '0;
         mem_re <= 1'b0;
         mem_we <= 1'b0;
         mem_x <= '0;
         mem_y <= '0;
         mem_wdata <= 1'b0;
         {p1_v, p1_own, p1_oor, p2_v, p2_own, p2_oor} <= '0;
      end else begin
         state <= state_nx;
         vid_wait <= (!vid_req || vid_gnt) ? '0 : vid_wait + 4'(vid_wait != VMAX);
         clr_x <= (clr && clr_x != XMAX) ? clr_x + 4'd1 : '0;
         clr_y <= clr ? clr_y + 5'(clr_x == XMAX) : '0;
         mem_re <= acc && !acc_we && in_range;
         mem_we <= clr || (acc && acc_we && in_range);
         mem_x <= clr ? clr_x : acc_x;
         mem_y <= clr ? clr_y : acc_y;
         mem_wdata <= !clr && acc_wd;
         p1_v <= acc && !acc_we;
         p1_own <= vid_gnt;
         p1_oor <= !in_range;
         p2_v <= p1_v;
         p2_own <= p1_own;
         p2_oor <= p1_oor;
      end
   end

   // out-of-range reads behave as wall for the game and empty for the renderer
   assign game_rvalid = p2_v && !p2_own;
   assign vid_rvalid = p2_v && p2_own;
   assign game_rdata = game_rvalid && (p2_oor || mem_rdata);
   assign vid_rdata = vid_rvalid && !p2_oor && mem_rdata;
endmodule

// File: tb/tb_board_arbiter.sv
// tb_board_arbiter: directed and random traffic against a cell-level reference
// model of the arbiter, with a behavioural synchronous-read board RAM.
module tb_board_arbiter;
   localparam int COLS = 10, ROWS = 20, MAXW = 4, CELLS = 200;

   logic CLOCK_50 = 0, resetn = 0, clear_req = 0;
   logic game_req = 0, game_we = 0, game_wdata = 0, vid_req = 0;
   logic [3:0] game_x = 0, vid_x = 0;
   logic [4:0] game_y = 0, vid_y = 0;
   logic clear_busy, game_gnt, game_rvalid, game_rdata, vid_gnt, vid_rvalid, vid_rdata;
   logic mem_re, mem_we, mem_wdata;
   logic [3:0] mem_x;
   logic [4:0] mem_y;
   logic mem_rdata = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   board_arbiter dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .clear_req(clear_req), .clear_busy(clear_busy),
      .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
      .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rvalid(game_rvalid),
      .game_rdata(game_rdata), .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y),
      .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .mem_re(mem_re), .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   bit ram[CELLS];
   int ram_idx;
   assign ram_idx = int'(mem_y) * COLS + int'(mem_x);
   always @(posedge CLOCK_50) begin
      if (mem_we && ram_idx < CELLS) ram[ram_idx] <= mem_wdata;
      if (mem_re && ram_idx < CELLS) mem_rdata <= ram[ram_idx];
   end

   typedef struct {int due; bit own; bit data;} ret_t;
   ret_t q[$];
   bit board[CELLS];
   bit m_clear, pa_re, pa_we, pa_wd, last_eg, last_ev;
   bit obs_gg, obs_vg, obs_we, obs_busy;
   int m_cnt, denied, cyc, pa_x, pa_y, tests, fails;
   int vcount, busy, wr, first_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // one clock: inputs were set just after the last edge; check, then advance the model
   task automatic step();
      bit eg, ev, gv, gd, vv, vd, inr, we;
      int x, y;
      ret_t r;
      #1;
      eg = 0;
      ev = 0;
      if (!m_clear && !clear_req) begin
         ev = vid_req && (!game_req || denied >= MAXW);
         eg = game_req && !ev;
      end
      obs_gg = game_gnt;
      obs_vg = vid_gnt;
      obs_we = mem_we;
      obs_busy = clear_busy;
      chk("game_gnt", game_gnt, eg);
      chk("vid_gnt", vid_gnt, ev);
      chk("clear_busy", clear_busy, m_clear);
      chk("mem_re", mem_re, pa_re);
      chk("mem_we", mem_we, pa_we);
      if (pa_re || pa_we) begin
         chk("mem_x", mem_x, pa_x);
         chk("mem_y", mem_y, pa_y);
      end
      if (pa_we) chk("mem_wdata", mem_wdata, pa_wd);
      {gv, gd, vv, vd} = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         r = q.pop_front();
         if (r.own) {vv, vd} = {1'b1, r.data};
         else {gv, gd} = {1'b1, r.data};
      end
      chk("game_rvalid", game_rvalid, gv);
      chk("game_rdata", game_rdata, gd);
      chk("vid_rvalid", vid_rvalid, vv);
      chk("vid_rdata", vid_rdata, vd);
      pa_re = 0;
      pa_we = 0;
      pa_wd = 0;
      if (m_clear) begin
         pa_we = 1;
         pa_x = m_cnt % COLS;
         pa_y = m_cnt / COLS;
         board[m_cnt] = 0;
         m_cnt++;
         m_clear = m_cnt < CELLS;
      end else if (clear_req) begin
         m_clear = 1;
         m_cnt = 0;
      end else if (eg || ev) begin
         x = ev ? int'(vid_x) : int'(game_x);
         y = ev ? int'(vid_y) : int'(game_y);
         we = eg && game_we;
         inr = x < COLS && y < ROWS;
         pa_x = x;
         pa_y = y;
         pa_re = !we && inr;
         pa_we = we && inr;
         pa_wd = game_wdata;
         if (pa_we) board[y * COLS + x] = game_wdata;
         if (!we) q.push_back('{cyc + 2, ev, inr ? board[y * COLS + x] : !ev});
      end
      denied = (vid_req && !ev) ? (denied < MAXW ? denied + 1 : MAXW) : 0;
      last_eg = eg;
      last_ev = ev;
      @(posedge CLOCK_50);
      #1;
      cyc++;
   endtask

   initial begin
      game_req = 1;
      vid_req = 1;
      #12;
      chk("rst_game_gnt", game_gnt, 0);
      chk("rst_vid_gnt", vid_gnt, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_xy", {mem_x, mem_y, mem_wdata}, 0);
      chk("rst_rvalid", {game_rvalid, vid_rvalid, game_rdata, vid_rdata}, 0);
      chk("rst_clear_busy", clear_busy, 0);
      game_req = 0;
      vid_req = 0;
      @(negedge CLOCK_50) resetn = 1;
      @(posedge CLOCK_50);
      #1;
      // seed (3,5)=1, then read it alone
      {game_req, game_we, game_x, game_y, game_wdata} = {1'b1, 1'b1, 4'd3, 5'd5, 1'b1};
      step();
      game_req = 0;
      step();
      {game_req, game_we} = 2'b10;
      step();
      game_req = 0;
      repeat (3) step();
      // contention: 4 game grants then 1 vid grant, repeating
      vcount = 0;
      {game_req, game_x, game_y, vid_req, vid_x, vid_y} = {1'b1, 4'd3, 5'd5, 1'b1, 4'd2, 5'd2};
      repeat (15) begin
         step();
         vcount += int'(obs_vg);
      end
      chk("contention_vid_grants", vcount, 3);
      {game_req, vid_req} = 2'b00;
      repeat (3) step();
      // out-of-range reads
      {game_req, game_x, game_y} = {1'b1, 4'd10, 5'd0};
      step();
      {game_req, vid_req, vid_x, vid_y} = {1'b0, 1'b1, 4'd0, 5'd20};
      step();
      vid_req = 0;
      repeat (3) step();
      // write then immediate read of (4,7)
      {game_req, game_we, game_x, game_y, game_wdata} = {1'b1, 1'b1, 4'd4, 5'd7, 1'b1};
      step();
      game_we = 0;
      step();
      game_req = 0;
      repeat (3) step();
      // clear with a pending game request, plus an ignored clear_req mid-sweep
      {game_req, game_x, game_y, clear_req} = {1'b1, 4'd4, 5'd7, 1'b1};
      busy = 0;
      wr = 0;
      first_g = -1;
      for (int i = 0; i < 202; i++) begin
         clear_req = i == 0 || i == 50;
         step();
         busy += int'(obs_busy);
         wr += int'(obs_we);
         if (obs_gg && first_g < 0) first_g = i;
      end
      clear_req = 0;
      chk("clear_busy_cycles", busy, 200);
      chk("clear_writes", wr, 200);
      chk("clear_first_grant", first_g, 201);
      game_req = 0;
      repeat (3) step();
      // random traffic
      repeat (3000) begin
         if (!game_req || last_eg) begin
            game_req = $urandom_range(0, 2) != 0;
            game_we = $urandom_range(0, 2) == 0;
            game_x = 4'($urandom_range(0, 11));
            game_y = 5'($urandom_range(0, 21));
            game_wdata = 1'($urandom_range(0, 1));
         end
         if (!vid_req || last_ev) begin
            vid_req = 1'($urandom_range(0, 1));
            vid_x = 4'($urandom_range(0, 10));
            vid_y = 5'($urandom_range(0, 20));
         end
         clear_req = $urandom_range(0, 299) == 0;
         step();
      end
      {game_req, vid_req, clear_req} = 3'b000;
      repeat (205) step();
      // reset 50 cycles into a clear
      clear_req = 1;
      step();
      clear_req = 0;
      repeat (50) step();
      #2 resetn = 0;
      #1;
      chk("midclr_mem_we", mem_we, 0);
      chk("midclr_clear_busy", clear_busy, 0);
      chk("midclr_rvalid", {game_rvalid, vid_rvalid}, 0);
      @(posedge CLOCK_50);
      #1 resetn = 1;
      {game_req, game_we, game_x, game_y} = {1'b1, 1'b0, 4'd1, 5'd1};
      wr = 0;
      repeat (30) begin
         @(posedge CLOCK_50);
         #2;
         wr += int'(mem_we);
         chk("post_rst_busy", clear_busy, 0);
         chk("post_rst_gnt", game_gnt, 1);
      end
      chk("post_rst_writes", wr, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
